// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined right shifter.
// Optional macro RSHIFT_ROTATE_EN enables the rotate-right operation.
package shifter_pkg;

    localparam int SH_WIDTH = 32;
    localparam int SH_AMT_W = 5;

    // Operation kind carried down the pipe with each operand.
    typedef enum logic [1:0] {
        LOGICAL = 2'd0,
        ARITH   = 2'd1,
        ROTATE  = 2'd2
    } sh_op_t;

    // Per-stage payload at the default width: data, full shift amount
    // (each stage consumes its own bit), fill bit and operation.
    typedef struct packed {
        logic [SH_WIDTH-1:0] data;
        logic [SH_AMT_W-1:0] sha;
        logic                fill;
        sh_op_t              op;
    } sh_payload_t;

endpackage

// File: rtl/rshift_stage.sv
// One registered log-shifter stage: shifts right by 2**K when sha[K] is set.
// Optional macro RSHIFT_ROTATE_EN adds the rotate path (vacated MSBs take
// the bits shifted out at the LSB end).
module rshift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = SH_WIDTH,
    parameter int SHW   = SH_AMT_W,
    parameter int K     = 0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
    input  logic [SHW-1:0]   up_sha_i,
    input  logic             up_fill_i,
    input  sh_op_t           up_op_i,
    output logic             dn_valid_o,
    output logic [WIDTH-1:0] dn_data_o,
    output logic [SHW-1:0]   dn_sha_o,
    output logic             dn_fill_o,
    output sh_op_t           dn_op_o
);

    localparam int S = 1 << K;

    logic             v_q;
    logic [WIDTH-1:0] data_d, data_q;
    logic [SHW-1:0]   sha_q;
    logic             fill_q;
    sh_op_t           op_q;

    // Shift-by-2**K mux; the fill bit supplies the vacated MSBs.
    always_comb begin
        data_d = up_data_i;
        if (up_sha_i[K]) begin
            data_d = {{S{up_fill_i}}, up_data_i[WIDTH-1:S]};
`ifdef RSHIFT_ROTATE_EN
            if (up_op_i == ROTATE) begin
                data_d = {up_data_i[S-1:0], up_data_i[WIDTH-1:S]};
            end
`endif
        end
    end

    // Valid bit: the only reset state; takes the upstream valid on load.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q <= 1'b0;
        end else if (load_i) begin
            v_q <= up_valid_i;
        end
    end

    // Payload registers: not reset, written only when the stage loads.
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            data_q <= data_d;
            sha_q  <= up_sha_i;
            fill_q <= up_fill_i;
            op_q   <= up_op_i;
        end
    end

    assign dn_valid_o = v_q;
    assign dn_data_o  = data_q;
    assign dn_sha_o   = sha_q;
    assign dn_fill_o  = fill_q;
    assign dn_op_o    = op_q;

endmodule

// File: rtl/right_shifter_pipe.sv
// Pipelined right barrel shifter (SRL / SRA), one registered stage per
// shift-amount bit. Optional macro RSHIFT_ROTATE_EN adds a rotate input
// that selects rotate-right (arith is then ignored).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a producer holding valid keeps its data stable until that edge,
// and ready never depends on the same side's valid.
module right_shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = SH_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in,
    input  logic [$clog2(WIDTH)-1:0]   sha,
    input  logic                       arith,
`ifdef RSHIFT_ROTATE_EN
    input  logic                       rotate,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out
);

    localparam int SHW = $clog2(WIDTH);

    // Inter-stage links: index k feeds stage k, index SHW is the pipe output.
    logic [SHW:0]     vld_c;
    logic [WIDTH-1:0] data_c [SHW+1];
    logic [SHW-1:0]   sha_c  [SHW+1];
    logic [SHW:0]     fill_c;
    sh_op_t           op_c   [SHW+1];
    logic [SHW-1:0]   rdy_c;
    sh_op_t           op_in;
    logic             unused_tail;

    // Classify the incoming operation; rotate takes priority over arith.
    always_comb begin
        op_in = arith ? ARITH : LOGICAL;
`ifdef RSHIFT_ROTATE_EN
        if (rotate) begin
            op_in = ROTATE;
        end
`endif
    end

    assign vld_c[0]  = in_valid;
    assign data_c[0] = in;
    assign sha_c[0]  = sha;
    assign fill_c[0] = (op_in == ARITH) && in[WIDTH-1];
    assign op_c[0]   = op_in;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        // Stage k may load when out_ready is high or any stage from k to the
        // end is empty -- the flattened form of ready_k = !v_k | ready_{k+1},
        // computed from registered valids so there is no combinational chain.
        assign rdy_c[k] = out_ready || !(&vld_c[SHW:k+1]);

        rshift_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .K     (k)
        ) u_stage (
            .clk_i      (clk),
            .reset_i    (reset),
            .load_i     (rdy_c[k]),
            .up_valid_i (vld_c[k]),
            .up_data_i  (data_c[k]),
            .up_sha_i   (sha_c[k]),
            .up_fill_i  (fill_c[k]),
            .up_op_i    (op_c[k]),
            .dn_valid_o (vld_c[k+1]),
            .dn_data_o  (data_c[k+1]),
            .dn_sha_o   (sha_c[k+1]),
            .dn_fill_o  (fill_c[k+1]),
            .dn_op_o    (op_c[k+1])
        );
    end

    assign in_ready  = rdy_c[0];
    assign out_valid = vld_c[SHW];
    // Data registers are not reset, so mask the output while nothing is held.
    assign out       = vld_c[SHW] ? data_c[SHW] : '0;

    // Control fields are spent once the last stage has shifted.
    assign unused_tail = ^{sha_c[SHW], fill_c[SHW], op_c[SHW]};

endmodule

// File: doc/right_shifter_pipe.md
Name: right_shifter_pipe

Overview:
- Pipelined right barrel shifter: the right-shift counterpart of the combinational left shifter in the RISC datapath ALU.
- One log-shifter stage per shift-amount bit (1, 2, 4, 8, 16), each registered.
- Supports logical (SRL) and arithmetic (SRA) shifts with a valid/ready handshake on both sides.
- Sits between the ALU operand latch and the writeback mux; accepts one operation per cycle when not stalled.

Parameters:
- WIDTH, 32, data width; must be a power of two ≥ 2.
- SHW, $clog2(WIDTH) = 5, shift-amount width and number of pipeline stages; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream operation present.
- in_ready  output  1  block can accept an operation this cycle.
- in  input  WIDTH  operand.
- sha  input  SHW  shift amount, 0..WIDTH-1.
- arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out  output  WIDTH  shifted result.

Behaviour:
- Pipeline stages k = 0..SHW-1. Each stage holds: v_k, data_k, remaining shift bits, fill bit.
- Stage k shifts right by 2^k when sha[k] = 1; otherwise it passes data unchanged.
  - Vacated MSBs take the fill bit.
  - Fill bit = arith & in[WIDTH-1], captured at stage 0 and carried down the pipe.
- Transfers:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - out_valid = v_{SHW-1}; out = data_{SHW-1}.
- Backpressure: ready_SHW = out_ready; ready_k = !v_k | ready_{k+1}; in_ready = ready_0.
  - Stage k loads from stage k-1 (or from the input for k = 0) when ready_k.
  - v_k takes the upstream valid on load and holds otherwise.
  - A full pipe with out_ready=1 accepts and emits one operation per cycle.
- Latency: SHW cycles (5) from input transfer to out_valid, when unstalled.
- Stall: out_ready=0 with the pipe full → in_ready=0 and every stage holds. Bubbles collapse: empty stages keep filling until every stage is full.
- data_k is not reset; only v_k is cleared. Data registers load only when ready_k.
- Reset:
  - All v_k = 0, so out_valid = 0 and out is don't-care (implementation drives 0).
  - in_ready = 1 in the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight results; none appear after reset.
- Boundaries:
  - sha = 0 → out = in.
  - sha = WIDTH-1 → logical gives 0 or 1; arithmetic gives all-sign.
  - in_valid while in_ready=0 → no transfer; upstream must hold its inputs.
  - arith ignored for non-negative operands (fill = 0).
- Ordering: strict FIFO; no reordering, no drop.

Optional Feature:
- Macro RSHIFT_ROTATE_EN.
- Defined:
  - Adds input port rotate (1 bit), carried down the pipe with the operation.
  - When rotate=1, each stage's vacated MSBs take the bits shifted out at the LSB end (ROR). arith is ignored.
- Undefined: no rotate port; behaviour exactly as above.

Decomposition:
- Package shifter_pkg:
  - SH_WIDTH = 32, SH_AMT_W = 5.
  - Typedef sh_op_t {LOGICAL, ARITH, ROTATE}.
  - Typedef for the per-stage payload struct: data, remaining sha, fill, op.
- Sub-module rshift_stage (parameter K):
  - One registered 2^K right-shift mux with valid/ready.
  - Instantiated SHW times via generate.

Test Plan:
- 32'h8000_0000, sha=4, arith=0 → out=32'h0800_0000 exactly 5 cycles after acceptance.
- 32'h8000_0000, sha=4, arith=1 → out=32'hF800_0000.
- 32'hDEAD_BEEF, sha=0 with either arith → out=32'hDEAD_BEEF. 32'hFFFF_FFFF, sha=31, arith=0 → 32'h0000_0001.
- Back-to-back: 8 operations with sha = 0..7 on in = 32'h0000_FF00, out_ready held 1 → 8 consecutive out_valid cycles, results 32'h0000_FF00 >> i, in order.
- Stall: fill the pipe, drop out_ready for 3 cycles → in_ready=0, out held stable. Raise out_ready → all results emitted in order, none lost or duplicated.
- Reset mid-stream with 3 operations in flight → out_valid=0 the next cycle, nothing emitted afterwards. With RSHIFT_ROTATE_EN: 32'h0000_0001, sha=1, rotate=1 → 32'h8000_0000.
